// File: rtl/io_controller_if.sv
// Data-memory port bus between the processor and the memory-mapped I/O slave.
// The processor drives the store strobe, address and store data. The slave returns the
// read data and the I/O page hit flag that steers the data-memory mux.
interface io_controller_if #(
  parameter int DBITS = 32
);
  logic             wrEn;
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] dataIn;
  logic [DBITS-1:0] dataOut;
  logic             isIo;

  modport master (output wrEn, addr, dataIn, input dataOut, isIo);
  modport slave  (input wrEn, addr, dataIn, output dataOut, isIo);
endinterface

// File: rtl/io_controller.sv
// Memory-mapped I/O slave for the 0xF0000000 page.
// It holds the HEX, LEDR and LEDG output registers.
// It synchronises and debounces the KEY and SW board inputs.
// Reads are combinational and zero-extended. A read of a register that is written in the
// same cycle returns the old value.
// Optional feature macro: IO_KEY_EDGE_EN. When it is defined, the block adds sticky
// key-press flags in KEY read bits [7:4], and a write of 1 to a bit clears that flag.

// One debounce engine per input bank: 2-FF synchroniser followed by a stability counter.
// The bank is debounced as a whole, so a change in any bit restarts the count.
module io_debounce #(
  parameter int             W      = 4,
  parameter int             CYCLES = 50,
  parameter logic [W-1:0]   INIT   = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw,
  output logic [W-1:0] deb
);
  localparam int            CW   = $clog2(CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [W-1:0]  s1, s2, cand;
  logic [CW-1:0] cnt;

  // Synchronise, track the candidate value and accept it after CYCLES stable cycles.
  // The counter saturates at LAST, so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= INIT;
      s2   <= INIT;
      cand <= INIT;
      cnt  <= '0;
      deb  <= INIT;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (cnt == LAST) begin
        deb <= cand;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module io_controller #(
  parameter int               DBITS           = 32,
  parameter int               DEBOUNCE_CYCLES = 50,
  parameter logic [DBITS-1:0] ADDR_HEX        = 32'hF0000000,
  parameter logic [DBITS-1:0] ADDR_LEDR       = 32'hF0000004,
  parameter logic [DBITS-1:0] ADDR_LEDG       = 32'hF0000008,
  parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014
) (
  input  logic            clk,
  input  logic            reset,
  io_controller_if.slave  bus,
  input  logic [3:0]      KEY,
  input  logic [9:0]      SW,
  output logic [15:0]     hexOut,
  output logic [9:0]      ledr,
  output logic [7:0]      ledg
);
  logic [3:0] key_deb;   // raw polarity: 1 = released
  logic [3:0] key_prs;   // 1 = pressed
  logic [9:0] sw_deb;
  logic       sel_hex, sel_ledr, sel_ledg, sel_key, sel_sw;
  logic [7:0] key_rd;

  // KEY is active-low, so the KEY bank starts in the released state.
  io_debounce #(.W(4), .CYCLES(DEBOUNCE_CYCLES), .INIT(4'hF)) u_key_deb (
    .clk(clk), .reset(reset), .raw(KEY), .deb(key_deb)
  );

  io_debounce #(.W(10), .CYCLES(DEBOUNCE_CYCLES), .INIT(10'h000)) u_sw_deb (
    .clk(clk), .reset(reset), .raw(SW), .deb(sw_deb)
  );

  assign key_prs = ~key_deb;

  // Exact-match address decode; the high-nibble test alone drives the mux select.
  always_comb begin
    bus.isIo = (bus.addr[DBITS-1:DBITS-4] == 4'hF);
    sel_hex  = (bus.addr == ADDR_HEX);
    sel_ledr = (bus.addr == ADDR_LEDR);
    sel_ledg = (bus.addr == ADDR_LEDG);
    sel_key  = (bus.addr == ADDR_KEY);
    sel_sw   = (bus.addr == ADDR_SW);
  end

  // Output registers; SW, KEY, unmapped and non-I/O writes fall through untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      hexOut <= '0;
      ledr   <= '0;
      ledg   <= '0;
    end else if (bus.wrEn) begin
      if (sel_hex)  hexOut <= bus.dataIn[15:0];
      if (sel_ledr) ledr   <= bus.dataIn[9:0];
      if (sel_ledg) ledg   <= bus.dataIn[7:0];
    end
  end

`ifdef IO_KEY_EDGE_EN
  logic [3:0] key_prs_q;
  logic [3:0] key_flag;
  logic [3:0] key_clr;

  assign key_clr = (bus.wrEn && sel_key) ? bus.dataIn[7:4] : 4'h0;

  // Sticky press flags: set on a debounced press edge and cleared by write-1.
  // The set term is ORed in last, so a set and a clear in the same cycle leave the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_prs_q <= '0;
      key_flag  <= '0;
    end else begin
      key_prs_q <= key_prs;
      key_flag  <= (key_flag & ~key_clr) | (key_prs & ~key_prs_q);
    end
  end

  assign key_rd = {key_flag, key_prs};
`else
  assign key_rd = {4'h0, key_prs};
`endif

  // Read mux uses the pre-edge register contents, so a same-cycle write reads the old value.
  always_comb begin
    bus.dataOut = '0;
    if (sel_hex)       bus.dataOut = DBITS'(hexOut);
    else if (sel_ledr) bus.dataOut = DBITS'(ledr);
    else if (sel_ledg) bus.dataOut = DBITS'(ledg);
    else if (sel_key)  bus.dataOut = DBITS'(key_rd);
    else if (sel_sw)   bus.dataOut = DBITS'(sw_deb);
  end
endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller with DEBOUNCE_CYCLES=4.
// Register access is driven from a vector table. Debounce latency, glitch rejection,
// key flags and reset during a debounce are checked by hand-written sequences.
module tb_io_controller;
  localparam logic [31:0] A_HEX  = 32'hF0000000;
  localparam logic [31:0] A_LEDR = 32'hF0000004;
  localparam logic [31:0] A_LEDG = 32'hF0000008;
  localparam logic [31:0] A_KEY  = 32'hF0000010;
  localparam logic [31:0] A_SW   = 32'hF0000014;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [15:0] hexOut;
  logic [9:0]  ledr;
  logic [7:0]  ledg;

  int checks = 0;
  int errors = 0;

  io_controller_if #(.DBITS(32)) bus ();

  io_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .bus(bus), .KEY(KEY), .SW(SW),
    .hexOut(hexOut), .ledr(ledr), .ledg(ledg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        isio;
    logic [15:0] hex;
    logic [9:0]  ledr;
    logic [7:0]  ledg;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.wrEn = 1'b0;
    bus.addr = a;
    #1;
    d = bus.dataOut;
  endtask

  logic [31:0] r;

  initial begin
    vecs[0]  = '{1'b1, A_HEX,        32'hABCD1234, 32'h0,    1'b1, 16'h1234, 10'h000, 8'h00};
    vecs[1]  = '{1'b0, A_HEX,        32'h00005555, 32'h1234, 1'b1, 16'h1234, 10'h000, 8'h00};
    vecs[2]  = '{1'b1, A_LEDR,       32'hFFFFFFFF, 32'h0,    1'b1, 16'h1234, 10'h3FF, 8'h00};
    vecs[3]  = '{1'b1, A_LEDG,       32'h000001A5, 32'h0,    1'b1, 16'h1234, 10'h3FF, 8'hA5};
    vecs[4]  = '{1'b0, A_LEDR,       32'h00000000, 32'h3FF,  1'b1, 16'h1234, 10'h3FF, 8'hA5};
    vecs[5]  = '{1'b1, A_LEDG,       32'h0000003C, 32'hA5,   1'b1, 16'h1234, 10'h3FF, 8'h3C};
    vecs[6]  = '{1'b1, A_SW,         32'h0000FFFF, 32'h0,    1'b1, 16'h1234, 10'h3FF, 8'h3C};
    vecs[7]  = '{1'b1, 32'hF0000018, 32'h00000001, 32'h0,    1'b1, 16'h1234, 10'h3FF, 8'h3C};
    vecs[8]  = '{1'b1, 32'h00000100, 32'h0000FFFF, 32'h0,    1'b0, 16'h1234, 10'h3FF, 8'h3C};
    vecs[9]  = '{1'b1, 32'h00000000, 32'h0000FFFF, 32'h0,    1'b0, 16'h1234, 10'h3FF, 8'h3C};
    vecs[10] = '{1'b1, 32'hF0000001, 32'h0000FFFF, 32'h0,    1'b1, 16'h1234, 10'h3FF, 8'h3C};
    vecs[11] = '{1'b1, 32'h70000004, 32'h0000FFFF, 32'h0,    1'b0, 16'h1234, 10'h3FF, 8'h3C};
    vecs[12] = '{1'b1, A_KEY,        32'h000000F0, 32'h0,    1'b1, 16'h1234, 10'h3FF, 8'h3C};
    vecs[13] = '{1'b0, A_HEX,        32'h00000000, 32'h1234, 1'b1, 16'h1234, 10'h3FF, 8'h3C};

    // Reset state
    reset = 1'b1; KEY = 4'hF; SW = '0;
    bus.wrEn = 1'b0; bus.addr = '0; bus.dataIn = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_hex",  32'(hexOut), 32'h0);
    chk("rst_ledr", 32'(ledr),   32'h0);
    chk("rst_ledg", 32'(ledg),   32'h0);
    rd(A_KEY, r); chk("rst_key_rd", r, 32'h0);
    rd(A_SW, r);  chk("rst_sw_rd",  r, 32'h0);

    // Register access vectors: the read is checked before the edge, so it shows the old value.
    for (int i = 0; i < 14; i++) begin
      bus.wrEn = vecs[i].wr; bus.addr = vecs[i].addr; bus.dataIn = vecs[i].din;
      #1;
      chk($sformatf("v%0d_dout", i), bus.dataOut, vecs[i].dout);
      chk($sformatf("v%0d_isio", i), 32'(bus.isIo), 32'(vecs[i].isio));
      tick();
      chk($sformatf("v%0d_hex", i),  32'(hexOut), 32'(vecs[i].hex));
      chk($sformatf("v%0d_ledr", i), 32'(ledr),   32'(vecs[i].ledr));
      chk($sformatf("v%0d_ledg", i), 32'(ledg),   32'(vecs[i].ledg));
    end
    bus.wrEn = 1'b0;

    // Short SW pulse (3 cycles) is rejected.
    SW = 10'h001;
    tick(); tick(); tick();
    SW = 10'h000;
    for (int k = 0; k < 10; k++) begin
      rd(A_SW, r); chk($sformatf("pulse_sw_%0d", k), r, 32'h0);
      tick();
    end

    // SW latency: 0 through edge R+5, value after edge R+6.
    SW = 10'h2A5;
    for (int k = 0; k <= 5; k++) begin
      tick();
      rd(A_SW, r); chk($sformatf("sw_lat_R%0d", k), r, 32'h0);
    end
    tick();
    rd(A_SW, r); chk("sw_lat_R6", r, 32'h2A5);

    // KEY[2] pressed
    KEY = 4'hB;
    for (int k = 0; k <= 5; k++) begin
      tick();
      rd(A_KEY, r); chk($sformatf("key_lat_R%0d", k), r, 32'h0);
    end
    tick();
    rd(A_KEY, r); chk("key_lat_R6", r, 32'h4);
`ifdef IO_KEY_EDGE_EN
    tick();
    rd(A_KEY, r); chk("key_flag_set", r, 32'h44);
    bus.wrEn = 1'b1; bus.addr = A_KEY; bus.dataIn = 32'h40;
    tick();
    rd(A_KEY, r); chk("key_flag_clr", r, 32'h04);
    KEY = 4'hF;
    for (int k = 0; k < 8; k++) tick();
    rd(A_KEY, r); chk("key_release", r, 32'h0);
    // Press again and clear on the edge where the flag sets: set wins.
    KEY = 4'hB;
    for (int k = 0; k <= 6; k++) tick();
    bus.wrEn = 1'b1; bus.addr = A_KEY; bus.dataIn = 32'h40;
    tick();
    rd(A_KEY, r); chk("key_set_wins", r, 32'h44);
`else
    bus.wrEn = 1'b1; bus.addr = A_KEY; bus.dataIn = 32'hF0;
    tick();
    rd(A_KEY, r); chk("key_wr_ignored", r, 32'h4);
`endif
    bus.wrEn = 1'b0;
    KEY = 4'hF;

    // Reset during a SW debounce discards it; debounce restarts from scratch.
    reset = 1'b1; SW = 10'h000; tick(); reset = 1'b0;
    rd(A_SW, r); chk("rst2_sw", r, 32'h0);
    SW = 10'h155;
    tick(); tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    rd(A_SW, r); chk("mid_rst_E0", r, 32'h0);
    chk("mid_rst_hex", 32'(hexOut), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      rd(A_SW, r); chk($sformatf("mid_rst_E%0d", k), r, 32'h0);
    end
    tick();
    rd(A_SW, r); chk("mid_rst_E7", r, 32'h155);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bound on total run time
  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
